pc_gen: RTL and testbench

Parametrised program-counter generator for the Team6 RV32 core, the successor to the fixed-width PC register. It holds the architectural PC and computes the next PC from sequential, branch and JALR sources, with stall, fetch handshake, halt/resume and misaligned-target handling. It sits between the control/ALU stage, which supplies the source select and operands, and instruction memory, which consumes `PC`.

---
 rtl/pc_gen_if.sv | 28 ++
 rtl/pc_gen.sv | 134 +++++++++++++
 tb/tb_pc_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Interface between the control/ALU stage (master) and the PC generator (slave).
// Carries the next-PC select, operands, pipeline controls and the fetch address.
interface pc_gen_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            PCsrc;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic                  stall;
    logic                  halt;
    logic                  resume;
    logic                  fetch_ready;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] PCPlus;
    logic                  trap;
    logic [DATA_WIDTH-1:0] bad_target;

    modport master (
        output PCsrc, imm_ext, rs1_val, stall, halt, resume, fetch_ready,
        input  fetch_valid, PC, PCPlus, trap, bad_target
    );

    modport slave (
        input  PCsrc, imm_ext, rs1_val, stall, halt, resume, fetch_ready,
        output fetch_valid, PC, PCPlus, trap, bad_target
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALTED FSM, sequential/branch/JALR next-PC, one-cycle update.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned targets; otherwise they are force-aligned.
module pc_gen #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INC          = 4,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(32'h0000_0100)
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.slave   bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'(INC - 1);

    if (DATA_WIDTH < 8) begin : g_bad_width
        $error("pc_gen: DATA_WIDTH must be at least 8");
    end
    if (INC != 2 && INC != 4) begin : g_bad_inc
        $error("pc_gen: INC must be 2 or 4");
    end
    if ((TRAP_VECTOR & LOW_MASK) != '0) begin : g_bad_trap_vec
        $error("pc_gen: TRAP_VECTOR must be INC-aligned");
    end

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_fetch_valid;

    logic [DATA_WIDTH-1:0] w_seq;
    logic [DATA_WIDTH-1:0] w_branch;
    logic [DATA_WIDTH-1:0] w_jalr;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_is_bj;
    logic                  w_advance;

    assign w_seq    = r_pc + DATA_WIDTH'(INC);
    assign w_branch = r_pc + bus.imm_ext;
    assign w_jalr   = (bus.rs1_val + bus.imm_ext) & ~DATA_WIDTH'(1);

    always_comb begin
        w_target = w_seq;
        w_is_bj  = 1'b0;
        case (bus.PCsrc)
            2'b01: begin
                w_target = w_branch;
                w_is_bj  = 1'b1;
            end
            2'b10: begin
                w_target = w_jalr;
                w_is_bj  = 1'b1;
            end
            default: begin
                w_target = w_seq;
                w_is_bj  = 1'b0;
            end
        endcase
    end

    // fetch_valid is only ever high in RUN, so acceptance implies RUN
    assign w_advance = r_fetch_valid && bus.fetch_ready && !bus.stall;

`ifdef PC_MISALIGN_TRAP_EN
    logic                  r_trap;
    logic [DATA_WIDTH-1:0] r_bad_target;
    logic                  w_misaligned;

    assign w_misaligned = w_is_bj && ((w_target & LOW_MASK) != '0);
    assign w_next_pc    = w_target;
    assign bus.trap       = r_trap;
    assign bus.bad_target = r_bad_target;
`else
    assign w_next_pc      = w_is_bj ? (w_target & ~LOW_MASK) : w_target;
    assign bus.trap       = 1'b0;
    assign bus.bad_target = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            r_trap        <= 1'b0;
            r_bad_target  <= '0;
`endif
        end else begin
`ifdef PC_MISALIGN_TRAP_EN
            r_trap <= 1'b0;
`endif
            case (r_state)
                BOOT: begin
                    r_state       <= RUN;
                    r_fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (w_advance) begin
`ifdef PC_MISALIGN_TRAP_EN
                        // trap outranks halt: the faulting instruction never retires
                        if (w_misaligned) begin
                            r_pc         <= TRAP_VECTOR;
                            r_trap       <= 1'b1;
                            r_bad_target <= w_target;
                        end else
`endif
                        begin
                            r_pc <= w_next_pc;
                            if (bus.halt) begin
                                r_state       <= HALTED;
                                r_fetch_valid <= 1'b0;
                            end
                        end
                    end
                end
                HALTED: begin
                    if (bus.resume && !bus.halt) begin
                        r_state       <= RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC          = r_pc;
    assign bus.PCPlus      = r_pc + DATA_WIDTH'(INC);
    assign bus.fetch_valid = r_fetch_valid;
endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with a queue scoreboard popped by an independent monitor.
module tb_pc_gen;
    localparam int          DW   = 32;
    localparam logic [31:0] RV   = 32'h0000_1000;
    localparam logic [31:0] TV   = 32'h0000_0100;
    localparam logic [1:0]  SEQ  = 2'b00;
    localparam logic [1:0]  BR   = 2'b01;
    localparam logic [1:0]  JR   = 2'b10;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        trap;
        logic [31:0] bad;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    pc_gen_if #(.DATA_WIDTH(DW)) bus ();

    pc_gen #(
        .DATA_WIDTH  (DW),
        .RESET_VECTOR(RV),
        .INC         (4),
        .TRAP_VECTOR (TV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   pop_no   = 0;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h exp=%h", name, pop_no, got, expv);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled 2 time units after the edge
    always @(posedge clk) begin
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc",          bus.PC,                  e.pc);
            chk("pcplus",      bus.PCPlus,              e.pc + 32'd4);
            chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, e.fv});
            chk("trap",        {31'd0, bus.trap},        {31'd0, e.trap});
            chk("bad_target",  bus.bad_target,          e.bad);
            pop_no++;
        end
    end

    task automatic cyc(input logic r, input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic st, input logic hl,
                       input logic rs, input logic rdy, input logic [31:0] epc,
                       input logic efv, input logic etrap, input logic [31:0] ebad);
        rst             = r;
        bus.PCsrc       = src;
        bus.imm_ext     = imm;
        bus.rs1_val     = rs1;
        bus.stall       = st;
        bus.halt        = hl;
        bus.resume      = rs;
        bus.fetch_ready = rdy;
        sb.push_back(exp_t'{epc, efv, etrap, ebad});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bad1;
        logic [31:0] bad2;
        bad1 = TRAP_EN ? 32'h106 : 32'h0;
        bad2 = TRAP_EN ? 32'h202 : 32'h0;
        // reset and boot
        cyc(0, SEQ, 0, 0, 0, 0, 0, 1, RV, 0, 0, 0);
        cyc(0, SEQ, 0, 0, 0, 0, 0, 1, RV, 0, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, RV, 1, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, 32'h1004, 1, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, 32'h1008, 1, 0, 0);
        // branch, JALR, wrap-around
        cyc(1, JR,  0,            32'h2000,     0, 0, 0, 1, 32'h2000, 1, 0, 0);
        cyc(1, BR,  32'hFFFF_FFF8, 0,           0, 0, 0, 1, 32'h1FF8, 1, 0, 0);
        cyc(1, JR,  4,            32'h3001,     0, 0, 0, 1, 32'h3004, 1, 0, 0);
        cyc(1, JR,  0,            32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0);
        cyc(1, SEQ, 0,            0,            0, 0, 0, 1, 32'h0, 1, 0, 0);
        // stall and fetch handshake
        cyc(1, JR,  0, 32'h40, 0, 0, 0, 1, 32'h40, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, SEQ, 0, 0, 1, 0, 0, 1, 32'h40, 1, 0, 0);
        for (int i = 0; i < 2; i++) cyc(1, SEQ, 0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, 32'h44, 1, 0, 0);
        // halt and resume
        cyc(1, JR,  0, 32'h80, 0, 0, 0, 1, 32'h80, 1, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 1, 0, 1, 32'h84, 0, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, 32'h84, 0, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 1, 1, 1, 32'h84, 0, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 1, 1, 32'h84, 1, 0, 0);
        cyc(1, SEQ, 0, 0, 1, 1, 0, 1, 32'h84, 1, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, 32'h88, 1, 0, 0);
        // misaligned branch and JALR targets
        cyc(1, JR,  0, 32'h100, 0, 0, 0, 1, 32'h100, 1, 0, 0);
        cyc(1, BR,  6, 0, 0, 0, 0, 1, TRAP_EN ? TV : 32'h104, 1, TRAP_EN, bad1);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, TRAP_EN ? 32'h104 : 32'h108, 1, 0, bad1);
        cyc(1, JR,  0, 32'h202, 0, 0, 0, 1, TRAP_EN ? TV : 32'h200, 1, TRAP_EN, bad2);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, TRAP_EN ? 32'h104 : 32'h204, 1, 0, bad2);
        // reset while halted and stalled
        cyc(1, JR,  0, 32'h300, 0, 0, 0, 1, 32'h300, 1, 0, bad2);
        cyc(1, SEQ, 0, 0, 0, 1, 0, 1, 32'h304, 0, 0, bad2);
        cyc(0, SEQ, 0, 0, 1, 1, 0, 1, RV, 0, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, RV, 1, 0, 0);
        cyc(1, SEQ, 0, 0, 0, 0, 0, 1, 32'h1004, 1, 0, 0);

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
